// File: rtl/bcd_editor_n.sv
// rtl/bcd_editor_n.sv - signed-BCD accumulator/operand editor with cursor window, blink and binary-to-BCD load
//
// Optional feature macro: BCD_EDITOR_SAT_EN
//   defined   : out-of-range loads saturate to +/-(10^DIGITS-1) and convert normally, error stays 0
//   undefined : out-of-range loads set the sticky error flag and clear the accumulator
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   left, right         one-cycle cursor moves (toward MS / LS digit)
//   inc, dec            one-cycle edits of the digit under the cursor
//   sel_opnd            edit target (0 = accumulator, 1 = operand)
//   load_valid/ready    load handshake; load_value is signed two's complement
//   acc_bcd, opnd_bcd   DIGITS magnitude nibbles plus sign nibble on top (0 = +, 5 = -)
//   cursor, win_base    cursor position and lowest visible position
//   blink_mask          one-hot visible cursor slot during the blink phase
//   busy, error         conversion in progress, sticky overflow
module bcd_editor_n #(
    parameter int DIGITS    = 4,
    parameter int WINDOW    = 4,
    parameter int W         = 16,
    parameter int BLINK_DIV = 12500000,
    localparam int CW       = $clog2(DIGITS + 1),
    localparam int RW       = 4 * (DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left,
    input  logic          right,
    input  logic          inc,
    input  logic          dec,
    input  logic          sel_opnd,
    input  logic          load_valid,
    input  logic [W-1:0]  load_value,
    output logic          load_ready,
    output logic [RW-1:0] acc_bcd,
    output logic [RW-1:0] opnd_bcd,
    output logic [CW-1:0] cursor,
    output logic [CW-1:0] win_base,
    output logic [WINDOW-1:0] blink_mask,
    output logic          busy,
    output logic          error
);

    localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int NW      = (W > 1) ? $clog2(W) : 1;
    localparam int MAXV_I  = 10 ** DIGITS - 1;
    localparam int MW      = 4 * DIGITS;

    localparam logic [CW-1:0] C_DIGITS = CW'(DIGITS);
    localparam logic [CW-1:0] C_WMAX   = CW'(DIGITS + 1 - WINDOW);
    localparam logic [CW-1:0] C_WM1    = CW'(WINDOW - 1);
    localparam logic [W:0]    C_MAXV   = (W + 1)'(MAXV_I);

    logic [RW-1:0] r_acc, r_opnd;
    logic [CW-1:0] r_cursor, r_win_base;
    logic          r_busy, r_error, r_neg, r_phase;
    logic [W-1:0]  r_bin;
    logic [MW-1:0] r_bcd;
    logic [NW-1:0] r_cnt;
    logic [BW-1:0] r_blink_cnt;

    logic [W:0]    w_ext, w_mag;
    logic          w_ovf;
    logic [MW-1:0] w_adj, w_bcd_next;
    logic [RW-1:0] w_sel, w_edited;
    logic [3:0]    w_nib, w_new_nib;
    logic [CW-1:0] w_off;

    // Magnitude is formed in W+1 bits so the most-negative input cannot wrap.
    always_comb begin
        w_ext = {load_value[W-1], load_value};
        w_mag = w_ext[W] ? (~w_ext + 1'b1) : w_ext;
        w_ovf = (w_mag > C_MAXV);
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_bcd_next = {w_adj[MW-2:0], r_bin[W-1]};
    end

    // Digit edit; inc outranks dec when both pulse together. Sign nibble toggles 0 <-> 5.
    always_comb begin
        w_sel = sel_opnd ? r_opnd : r_acc;
        w_nib = w_sel[4*int'(r_cursor) +: 4];
        if (r_cursor == C_DIGITS)
            w_new_nib = (w_nib == 4'd0) ? 4'd5 : 4'd0;
        else if (inc)
            w_new_nib = (w_nib >= 4'd9) ? 4'd0 : w_nib + 4'd1;
        else
            w_new_nib = (w_nib == 4'd0) ? 4'd9 : w_nib - 4'd1;
        w_edited = w_sel;
        w_edited[4*int'(r_cursor) +: 4] = w_new_nib;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_opnd      <= '0;
            r_cursor    <= '0;
            r_win_base  <= '0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_neg       <= 1'b0;
            r_phase     <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_blink_cnt <= '0;
        end else begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (r_busy) begin
                r_bcd <= w_bcd_next;
                r_bin <= {r_bin[W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == NW'(W - 1)) begin
                    r_busy     <= 1'b0;
                    r_acc      <= {(r_neg ? 4'd5 : 4'd0), w_bcd_next};
                    r_opnd     <= '0;
                    r_cursor   <= '0;
                    r_win_base <= '0;
                end
            end else if (load_valid) begin
                r_bcd <= '0;
                r_cnt <= '0;
                r_neg <= w_ext[W] && (w_mag != '0);
`ifdef BCD_EDITOR_SAT_EN
                r_busy <= 1'b1;
                r_bin  <= w_ovf ? W'(MAXV_I) : w_mag[W-1:0];
`else
                if (w_ovf) begin
                    r_error <= 1'b1;
                    r_acc   <= '0;
                end else begin
                    r_busy <= 1'b1;
                    r_bin  <= w_mag[W-1:0];
                end
`endif
            end else if (left) begin
                if (r_cursor == C_DIGITS) begin
                    r_cursor   <= '0;
                    r_win_base <= '0;
                end else begin
                    r_cursor <= r_cursor + 1'b1;
                    if (r_cursor - r_win_base == C_WM1)
                        r_win_base <= r_win_base + 1'b1;
                end
            end else if (right) begin
                if (r_cursor == '0) begin
                    r_cursor   <= C_DIGITS;
                    r_win_base <= C_WMAX;
                end else begin
                    r_cursor <= r_cursor - 1'b1;
                    if (r_cursor == r_win_base)
                        r_win_base <= r_win_base - 1'b1;
                end
            end else if (inc || dec) begin
                if (sel_opnd)
                    r_opnd <= w_edited;
                else
                    r_acc <= w_edited;
            end
        end
    end

    always_comb begin
        w_off      = r_cursor - r_win_base;
        blink_mask = (!r_busy && r_phase) ? (WINDOW'(1) << w_off) : '0;
    end

    assign load_ready = !r_busy;
    assign acc_bcd    = r_acc;
    assign opnd_bcd   = r_opnd;
    assign cursor     = r_cursor;
    assign win_base   = r_win_base;
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_bcd_editor_n.sv
// tb/tb_bcd_editor_n.sv - directed self-checking bench for bcd_editor_n (DIGITS=4, WINDOW=3, W=16, BLINK_DIV=4)
module tb_bcd_editor_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        left = 0, right = 0, inc = 0, dec = 0, sel_opnd = 0;
    logic        load_valid = 0;
    logic [15:0] load_value = '0;
    logic        load_ready, busy, error;
    logic [19:0] acc_bcd, opnd_bcd;
    logic [2:0]  cursor, win_base;
    logic [2:0]  blink_mask;

    int n_checks = 0;
    int n_errors = 0;

    bcd_editor_n #(.DIGITS(4), .WINDOW(3), .W(16), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .inc(inc), .dec(dec),
        .sel_opnd(sel_opnd), .load_valid(load_valid), .load_value(load_value),
        .load_ready(load_ready), .acc_bcd(acc_bcd), .opnd_bcd(opnd_bcd),
        .cursor(cursor), .win_base(win_base), .blink_mask(blink_mask),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic cyc(input logic l, input logic r, input logic i, input logic d);
        left = l; right = r; inc = i; dec = d;
        @(negedge clk);
        left = 0; right = 0; inc = 0; dec = 0;
    endtask

    task automatic start_load(input logic [15:0] v);
        load_valid = 1'b1; load_value = v;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_pos(input string tag, input int c, input int w);
        check({tag, "_cur"}, {29'd0, cursor}, c);
        check({tag, "_win"}, {29'd0, win_base}, w);
    endtask

    logic [15:0] ld_vals [4] = '{16'd9999, 16'd0, 16'hFFFF, 16'hD8F1};
    logic [19:0] ld_exp  [4] = '{20'h09999, 20'h00000, 20'h50001, 20'h59999};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_acc", {12'd0, acc_bcd}, 0);
        check("rst_ready", {31'd0, load_ready}, 1);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a conversion
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        start_load(16'd1234);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_acc", {12'd0, acc_bcd}, 0);
        check("mid_rst_opnd", {12'd0, opnd_bcd}, 0);
        check_pos("mid_rst", 0, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_err", {31'd0, error}, 0);
        check("mid_rst_ready", {31'd0, load_ready}, 1);
        @(negedge clk);
        rst = 1'b0;

        // Blink: phase toggles every 4 edges after reset release; cursor moves to 1 at edge 6
        begin
            int ec = 0;
            for (int k = 1; k <= 12; k++) begin
                if (k == 6) left = 1'b1;
                @(negedge clk);
                left = 1'b0;
                if (k == 6) ec = 1;
                check($sformatf("blink_%0d", k), {29'd0, blink_mask},
                      ((k / 4) % 2 == 1) ? (32'd1 << ec) : 32'd0);
            end
        end
        cyc(0, 1, 0, 0);
        check_pos("back0", 0, 0);

        // Cursor scroll with WINDOW=3
        repeat (3) cyc(1, 0, 0, 0);
        check_pos("left3", 3, 1);
        cyc(1, 0, 0, 0);
        check_pos("left4", 4, 2);
        cyc(1, 0, 0, 0);
        check_pos("left5", 0, 0);
        cyc(0, 1, 0, 0);
        check_pos("right0", 4, 2);
        cyc(0, 1, 0, 0);
        check_pos("right4", 3, 2);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check_pos("wrap0", 0, 0);

        // Digit edits
        repeat (9) cyc(0, 0, 1, 0);
        check("inc9", {12'd0, acc_bcd}, 32'h00009);
        cyc(0, 0, 1, 0);
        check("inc10", {12'd0, acc_bcd}, 32'h00000);
        cyc(0, 0, 0, 1);
        check("dec_wrap", {12'd0, acc_bcd}, 32'h00009);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        check("sign_inc", {12'd0, acc_bcd}, 32'h50009);
        sel_opnd = 1'b1;
        cyc(0, 0, 1, 0);
        check("opnd_sign", {12'd0, opnd_bcd}, 32'h50000);
        check("acc_kept", {12'd0, acc_bcd}, 32'h50009);
        cyc(0, 1, 1, 1);
        check_pos("prio_right", 3, 2);
        check("prio_opnd", {12'd0, opnd_bcd}, 32'h50000);
        sel_opnd = 1'b0;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("sign_dec", {12'd0, acc_bcd}, 32'h00009);
        cyc(1, 0, 1, 0);
        check_pos("prio_left", 0, 0);
        check("prio_acc", {12'd0, acc_bcd}, 32'h00009);
        cyc(1, 0, 0, 0);

        // Load -1234: busy for 16 edges, edits and second load ignored
        start_load(16'hFB2E);
        check("ld_busy", {31'd0, busy}, 1);
        check("ld_ready", {31'd0, load_ready}, 0);
        cyc(1, 0, 1, 0);
        start_load(16'd5);
        repeat (13) @(negedge clk);
        check("ld_busy15", {31'd0, busy}, 1);
        @(negedge clk);
        check("ld_busy16", {31'd0, busy}, 0);
        check("ld_ready16", {31'd0, load_ready}, 1);
        check("ld_acc", {12'd0, acc_bcd}, 32'h51234);
        check("ld_opnd", {12'd0, opnd_bcd}, 0);
        check_pos("ld", 0, 0);

        for (int i = 0; i < 4; i++) begin
            start_load(ld_vals[i]);
            wait_idle();
            check($sformatf("tbl_acc_%0d", i), {12'd0, acc_bcd}, {12'd0, ld_exp[i]});
        end

`ifdef BCD_EDITOR_SAT_EN
        start_load(16'd10000);
        wait_idle();
        check("sat_pos", {12'd0, acc_bcd}, 32'h09999);
        start_load(16'hB1E0);
        wait_idle();
        check("sat_neg", {12'd0, acc_bcd}, 32'h59999);
        check("sat_err", {31'd0, error}, 0);
`else
        start_load(16'd10000);
        check("ovf_err", {31'd0, error}, 1);
        check("ovf_acc", {12'd0, acc_bcd}, 0);
        check("ovf_busy", {31'd0, busy}, 0);
        cyc(0, 0, 1, 0);
        check("ovf_edit", {12'd0, acc_bcd}, 32'h00001);
        check("ovf_sticky", {31'd0, error}, 1);
        start_load(16'h8000);
        check("minneg_acc", {12'd0, acc_bcd}, 0);
        check("minneg_busy", {31'd0, busy}, 0);
        start_load(16'd42);
        wait_idle();
        check("err_kept", {31'd0, error}, 1);
        check("after_err_acc", {12'd0, acc_bcd}, 32'h00042);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/bcd_editor_n.md
Name: bcd_editor_n

Overview:
- Parametrised signed-BCD entry/edit block for the calculator front end.
- Holds an accumulator and an operand, each with DIGITS magnitude digits plus a sign digit. A cursor with a scrolling display window steps across them, and inc/dec edit the digit under the cursor.
- Accepts signed binary results from the ALU through a valid/ready handshake and converts them to BCD with a multi-cycle double-dabble engine.
- Feeds the 7-segment display formatter, which receives the window base and a blink mask.

Parameters:
- DIGITS, 4, number of magnitude digits per register (1..8).
- WINDOW, 4, number of visible digit positions; legal range 1..DIGITS+1.
- W, 16, width of the signed binary load value; 10^DIGITS-1 must be representable.
- BLINK_DIV, 12500000, clk cycles per blink-phase toggle.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- left  in  1  one-cycle pulse; cursor moves toward the more-significant digit
- right  in  1  one-cycle pulse; cursor moves toward the less-significant digit
- inc  in  1  one-cycle pulse; increment the digit under the cursor
- dec  in  1  one-cycle pulse; decrement the digit under the cursor
- sel_opnd  in  1  edit target: 0 = accumulator, 1 = operand
- load_valid  in  1  load request
- load_value  in  W  signed two's-complement value to load
- load_ready  out  1  equals !busy
- acc_bcd  out  4*(DIGITS+1)  accumulator; top nibble is the sign (0 = +, 5 = -)
- opnd_bcd  out  4*(DIGITS+1)  operand; same format as acc_bcd
- cursor  out  clog2(DIGITS+1)  position 0..DIGITS; DIGITS is the sign position
- win_base  out  clog2(DIGITS+1)  lowest visible position
- blink_mask  out  WINDOW  one-hot mask of the visible cursor slot during the blink phase
- busy  out  1  conversion in progress
- error  out  1  sticky overflow flag

Behaviour:
- Reset: all outputs and internal registers are 0, including the blink counter and blink phase. load_ready = 1.
- Event priority, evaluated once per cycle: accepted load > left > right > inc > dec. Lower-priority pulses in the same cycle are dropped.
- While busy = 1, left/right/inc/dec are ignored.
- Cursor, left:
  - If cursor == DIGITS: cursor = 0, win_base = 0.
  - Otherwise: cursor + 1. If (cursor - win_base) == WINDOW-1, win_base also increments.
- Cursor, right:
  - If cursor == 0: cursor = DIGITS, win_base = DIGITS+1-WINDOW.
  - Otherwise: cursor - 1. If cursor == win_base, win_base also decrements.
- Invariant: win_base <= cursor <= win_base+WINDOW-1.
- Edit: inc/dec act on the register selected by sel_opnd.
  - Magnitude digit: inc wraps 9 -> 0; dec wraps 0 -> 9.
  - Sign digit: inc and dec both toggle 0 <-> 5.
  - Only the target digit changes. Negative zero is permitted while editing.
- Load accept: load_valid && !busy, all in the same clock edge.
  - Capture the magnitude |load_value| and the sign.
  - If the magnitude > 10^DIGITS-1: error = 1, acc = 0, no conversion, busy stays 0.
  - Otherwise: busy = 1 and double-dabble starts.
- Conversion:
  - One bit per cycle: add 3 to every nibble >= 5, then shift in the next MSB.
  - W cycles total. busy falls on the edge W cycles after accept; load_ready is high again on the following cycle.
  - On completion:
    - acc gets the BCD magnitude digits.
    - The sign nibble is 5 if the value is negative and nonzero, else 0.
    - opnd = 0, cursor = 0, win_base = 0.
    - error is not cleared.
- Magnitude of the most-negative W-bit value is computed in W+1 bits; it is always out of range for legal parameters.
- error clears only on rst.
- Blink:
  - Counter wraps at BLINK_DIV-1 and toggles the phase on each wrap.
  - blink_mask bit (cursor - win_base) = phase; all other bits 0.
  - blink_mask = 0 while busy.
- Reset mid-conversion aborts immediately; all state returns to reset values.

Optional Feature:
- Macro: BCD_EDITOR_SAT_EN.
- Defined: an out-of-range load saturates to magnitude 10^DIGITS-1 with the input's sign, runs a normal conversion, and leaves error at 0.
- Undefined: the error behaviour described under Behaviour.

Test Plan:
- Reset: assert rst mid-operation -> acc_bcd = opnd_bcd = 0, cursor = 0, win_base = 0, busy = 0, error = 0, load_ready = 1.
- Cursor scroll (DIGITS=4, WINDOW=3):
  - 3 lefts -> cursor = 3, win_base = 1.
  - 4th left -> cursor = 4, win_base = 2.
  - 5th left -> cursor = 0, win_base = 0.
  - right from 0 -> cursor = 4, win_base = 2.
- Digit edit:
  - inc on digit 0, 10 times -> digit returns to 0.
  - dec on digit 0 once -> acc_bcd = 0x00009.
  - inc at cursor 4 -> acc_bcd = 0x50009.
  - With sel_opnd = 1, only opnd_bcd changes.
- Load (W=16): load_value = -1234 -> busy for 16 cycles, load_ready low; acc_bcd = 0x51234, opnd_bcd = 0, cursor = 0. A second load_valid while busy is ignored.
- Overflow: load_value = 10000 without the macro -> error = 1 and acc_bcd = 0 on the next cycle, busy stays 0; edits still work and error remains 1.
- Saturation (BCD_EDITOR_SAT_EN defined, BLINK_DIV=4): load_value = -20000 -> acc_bcd = 0x59999, error = 0. blink_mask toggles every 4 cycles at bit (cursor - win_base).
